// File: rtl/rst_sequencer.sv
//------------------------------------------------------------------------------
// rst_sequencer: staggered multi-domain reset release with run-cycle limit.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module rst_sequencer #(
    parameter int NDOM      = 2,
    parameter int HOLD      = 10,
    parameter int STAGGER   = 4,
    parameter int RUN_LIMIT = 200,
    parameter int DONE_RST  = 0,
    parameter int CW        = 16
) (
    input  logic            iCLK,
    input  logic            iRST,
    input  logic            iSWRST,
    output logic [NDOM-1:0] oRST,
    output logic            oREADY,
    output logic            oDONE,
    output logic [CW-1:0]   oCYCLES
);

    localparam int c_span = HOLD + NDOM * STAGGER;
    localparam int c_need = ((c_span > RUN_LIMIT) ? c_span : RUN_LIMIT) + 1;

    generate
        if (NDOM < 1 || NDOM > 8 || HOLD < 1 || CW < $clog2(c_need)) begin : g_param_check
            $error("rst_sequencer: illegal NDOM/HOLD or CW too narrow for HOLD/STAGGER/RUN_LIMIT");
        end
    endgenerate

    localparam logic [1:0] c_st_hold    = 2'd0;
    localparam logic [1:0] c_st_release = 2'd1;
    localparam logic [1:0] c_st_run     = 2'd2;
    localparam logic [1:0] c_st_done    = 2'd3;

    localparam logic [CW-1:0]   c_one     = 1;
    localparam logic [CW-1:0]   c_ones    = '1;
    localparam logic [CW-1:0]   c_hold    = CW'(HOLD);
    localparam logic [CW-1:0]   c_stag_m1 = CW'((STAGGER > 0) ? STAGGER - 1 : 0);
    localparam logic [CW-1:0]   c_lim_m1  = CW'((RUN_LIMIT > 0) ? RUN_LIMIT - 1 : 0);
    localparam logic [3:0]      c_last    = 4'(NDOM - 1);
    localparam logic [NDOM-1:0] c_lsb     = 1;
    localparam logic [NDOM-1:0] c_all     = '1;

    logic [1:0]      r_state, w_state;
    logic [CW-1:0]   r_cnt, w_cnt;
    logic [3:0]      r_idx, w_idx;
    logic [NDOM-1:0] r_rst, w_rst;
    logic            r_ready, w_ready;
    logic            r_done, w_done;
    logic [CW-1:0]   r_cycles, w_cycles;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state  <= c_st_hold;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_rst    <= c_all;
            r_ready  <= 1'b0;
            r_done   <= 1'b0;
            r_cycles <= '0;
        end else begin
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_idx    <= w_idx;
            r_rst    <= w_rst;
            r_ready  <= w_ready;
            r_done   <= w_done;
            r_cycles <= w_cycles;
        end
    end

    // r_cnt serves as the hold counter in HOLD and the stagger counter in RELEASE.
    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_idx    = r_idx;
        w_rst    = r_rst;
        w_ready  = r_ready;
        w_done   = r_done;
        w_cycles = r_cycles;
        if (iSWRST) begin
            w_state  = c_st_hold;
            w_cnt    = '0;
            w_idx    = '0;
            w_rst    = c_all;
            w_ready  = 1'b0;
            w_done   = 1'b0;
            w_cycles = '0;
        end else begin
            case (r_state)
                c_st_hold: begin
                    if (r_cnt >= c_hold) begin
                        if (STAGGER == 0 || NDOM == 1) begin
                            w_rst    = '0;
                            w_ready  = 1'b1;
                            w_cycles = '0;
                            w_state  = c_st_run;
                        end else begin
                            w_rst   = r_rst & ~c_lsb;
                            w_idx   = 4'd1;
                            w_cnt   = '0;
                            w_state = c_st_release;
                        end
                    end else if (r_cnt != c_ones) begin
                        w_cnt = r_cnt + c_one;
                    end
                end
                c_st_release: begin
                    if (r_cnt >= c_stag_m1) begin
                        w_rst = r_rst & ~(c_lsb << r_idx);
                        w_cnt = '0;
                        if (r_idx == c_last) begin
                            w_ready  = 1'b1;
                            w_cycles = '0;
                            w_state  = c_st_run;
                        end else begin
                            w_idx = r_idx + 4'd1;
                        end
                    end else if (r_cnt != c_ones) begin
                        w_cnt = r_cnt + c_one;
                    end
                end
                c_st_run: begin
                    if (RUN_LIMIT > 0) begin
                        w_cycles = r_cycles + c_one;
                        if (r_cycles == c_lim_m1) begin
                            w_done  = 1'b1;
                            w_state = c_st_done;
                            if (DONE_RST != 0) begin
                                w_rst   = c_all;
                                w_ready = 1'b0;
                            end
                        end
                    end else if (r_cycles != c_ones) begin
                        w_cycles = r_cycles + c_one;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        oRST    = r_rst;
        oREADY  = r_ready;
        oDONE   = r_done;
        oCYCLES = r_cycles;
    end

endmodule

`default_nettype wire

// File: tb/tb_rst_sequencer.sv
//------------------------------------------------------------------------------
// tb_rst_sequencer: directed table and sequence checks on four configurations.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_rst_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1, rst_o = 1'b1;
    logic sw_a = 1'b0, sw_b = 1'b0, sw_c = 1'b0, sw_d = 1'b0;

    logic [1:0]  a_rst;  logic a_rdy, a_done; logic [15:0] a_cyc;
    logic [3:0]  b_rst;  logic b_rdy, b_done; logic [15:0] b_cyc;
    logic [1:0]  c_rst;  logic c_rdy, c_done; logic [7:0]  c_cyc;
    logic [1:0]  d_rst;  logic d_rdy, d_done; logic [15:0] d_cyc;

    rst_sequencer dut_a (
        .iCLK(clk), .iRST(rst_a), .iSWRST(sw_a),
        .oRST(a_rst), .oREADY(a_rdy), .oDONE(a_done), .oCYCLES(a_cyc)
    );
    rst_sequencer #(.NDOM(4), .STAGGER(0)) dut_b (
        .iCLK(clk), .iRST(rst_o), .iSWRST(sw_b),
        .oRST(b_rst), .oREADY(b_rdy), .oDONE(b_done), .oCYCLES(b_cyc)
    );
    rst_sequencer #(.RUN_LIMIT(0), .CW(8)) dut_c (
        .iCLK(clk), .iRST(rst_o), .iSWRST(sw_c),
        .oRST(c_rst), .oREADY(c_rdy), .oDONE(c_done), .oCYCLES(c_cyc)
    );
    rst_sequencer #(.DONE_RST(1), .RUN_LIMIT(5)) dut_d (
        .iCLK(clk), .iRST(rst_o), .iSWRST(sw_d),
        .oRST(d_rst), .oREADY(d_rdy), .oDONE(d_done), .oCYCLES(d_cyc)
    );

    typedef struct {
        int          dut;
        int          edge_n;
        logic [7:0]  rst;
        logic        ready;
        logic        done;
        logic [15:0] cyc;
    } vec_t;

    localparam int NV = 19;
    vec_t tbl [NV];
    int n_checks = 0;
    int n_errors = 0;

    function automatic vec_t mk(int d, int e, logic [7:0] r, logic rd, logic dn, logic [15:0] cy);
        vec_t v;
        v.dut = d; v.edge_n = e; v.rst = r; v.ready = rd; v.done = dn; v.cyc = cy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic chk_dut(input int d, input string tag, input logic [7:0] r, input logic rd,
                           input logic dn, input logic [15:0] cy);
        logic [7:0] ar; logic ard, adn; logic [15:0] acy;
        case (d)
            0: begin ar = {6'd0, a_rst}; ard = a_rdy; adn = a_done; acy = a_cyc; end
            1: begin ar = {4'd0, b_rst}; ard = b_rdy; adn = b_done; acy = b_cyc; end
            2: begin ar = {6'd0, c_rst}; ard = c_rdy; adn = c_done; acy = {8'd0, c_cyc}; end
            default: begin ar = {6'd0, d_rst}; ard = d_rdy; adn = d_done; acy = d_cyc; end
        endcase
        chk($sformatf("dut%0d %s oRST", d, tag), 32'(ar), 32'(r));
        chk($sformatf("dut%0d %s oREADY", d, tag), 32'(ard), 32'(rd));
        chk($sformatf("dut%0d %s oDONE", d, tag), 32'(adn), 32'(dn));
        chk($sformatf("dut%0d %s oCYCLES", d, tag), 32'(acy), 32'(cy));
    endtask

    initial begin
        int cur;
        // Edges counted from the first edge sampling reset low; rows sorted by edge.
        tbl[0]  = mk(0,   0, 8'h3, 0, 0, 0);
        tbl[1]  = mk(0,   9, 8'h3, 0, 0, 0);
        tbl[2]  = mk(1,   9, 8'hF, 0, 0, 0);
        tbl[3]  = mk(0,  10, 8'h2, 0, 0, 0);
        tbl[4]  = mk(1,  10, 8'h0, 1, 0, 0);
        tbl[5]  = mk(1,  11, 8'h0, 1, 0, 1);
        tbl[6]  = mk(0,  13, 8'h2, 0, 0, 0);
        tbl[7]  = mk(0,  14, 8'h0, 1, 0, 0);
        tbl[8]  = mk(2,  14, 8'h0, 1, 0, 0);
        tbl[9]  = mk(0,  15, 8'h0, 1, 0, 1);
        tbl[10] = mk(3,  18, 8'h0, 1, 0, 4);
        tbl[11] = mk(3,  19, 8'h3, 0, 1, 5);
        tbl[12] = mk(3,  40, 8'h3, 0, 1, 5);
        tbl[13] = mk(0, 213, 8'h0, 1, 0, 199);
        tbl[14] = mk(0, 214, 8'h0, 1, 1, 200);
        tbl[15] = mk(0, 240, 8'h0, 1, 1, 200);
        tbl[16] = mk(2, 268, 8'h0, 1, 0, 16'hFE);
        tbl[17] = mk(2, 269, 8'h0, 1, 0, 16'hFF);
        tbl[18] = mk(2, 290, 8'h0, 1, 0, 16'hFF);

        run(3);
        chk_dut(0, "in reset", 8'h3, 0, 0, 0);
        chk_dut(1, "in reset", 8'hF, 0, 0, 0);
        rst_a = 1'b0;
        rst_o = 1'b0;
        cur = -1;
        for (int i = 0; i < NV; i++) begin
            while (cur < tbl[i].edge_n) begin
                step();
                cur++;
            end
            chk_dut(tbl[i].dut, $sformatf("edge%0d", tbl[i].edge_n),
                    tbl[i].rst, tbl[i].ready, tbl[i].done, tbl[i].cyc);
        end

        // Software reset pulse out of DONE with reset reassertion.
        sw_d = 1'b1; step(); sw_d = 1'b0;
        chk_dut(3, "swrst", 8'h3, 0, 0, 0);
        run(10); chk_dut(3, "re edge9", 8'h3, 0, 0, 0);
        step();  chk_dut(3, "re edge10", 8'h2, 0, 0, 0);
        run(4);  chk_dut(3, "re edge14", 8'h0, 1, 0, 0);
        run(5);  chk_dut(3, "re edge19", 8'h3, 0, 1, 5);

        // Software reset held high keeps the sequence parked.
        sw_d = 1'b1; run(4);
        chk_dut(3, "swrst held", 8'h3, 0, 0, 0);
        sw_d = 1'b0;
        run(10); chk_dut(3, "held edge9", 8'h3, 0, 0, 0);
        step();  chk_dut(3, "held edge10", 8'h2, 0, 0, 0);

        // Hard reset out of DONE, then software pulse at oCYCLES=50.
        rst_a = 1'b1; run(2);
        chk_dut(0, "rst from done", 8'h3, 0, 0, 0);
        rst_a = 1'b0;
        run(65); chk_dut(0, "edge64", 8'h0, 1, 0, 50);
        sw_a = 1'b1; step(); sw_a = 1'b0;
        chk_dut(0, "swrst run", 8'h3, 0, 0, 0);
        run(10); chk_dut(0, "sw edge9", 8'h3, 0, 0, 0);
        step();  chk_dut(0, "sw edge10", 8'h2, 0, 0, 0);
        run(4);  chk_dut(0, "sw edge14", 8'h0, 1, 0, 0);

        // Hard reset mid-RELEASE discards the partial release.
        rst_a = 1'b1; step(); rst_a = 1'b0;
        run(13); chk_dut(0, "pre edge12", 8'h2, 0, 0, 0);
        rst_a = 1'b1; step(); rst_a = 1'b0;
        chk_dut(0, "rst mid release", 8'h3, 0, 0, 0);
        run(10); chk_dut(0, "rr edge9", 8'h3, 0, 0, 0);
        step();  chk_dut(0, "rr edge10", 8'h2, 0, 0, 0);
        run(4);  chk_dut(0, "rr edge14", 8'h0, 1, 0, 0);

        // Hard reset wins over a simultaneous software reset.
        rst_a = 1'b1; sw_a = 1'b1; step(); rst_a = 1'b0; sw_a = 1'b0;
        chk_dut(0, "rst+swrst", 8'h3, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rst_sequencer.md
RST_SEQUENCER -- requirements
Module: rst_sequencer

Interface
REQ-001 SHALL have parameter NDOM, default 2, number of reset domains (1..8).
REQ-002 SHALL have parameter HOLD, default 10, cycles all domains stay in reset after reset release (>=1).
REQ-003 SHALL have parameter STAGGER, default 4, cycles between consecutive domain releases (0 = release all together).
REQ-004 SHALL have parameter RUN_LIMIT, default 200, run cycles before oDONE (0 = unlimited).
REQ-005 SHALL have parameter DONE_RST, default 0; 1 = reassert all domain resets at oDONE.
REQ-006 SHALL have parameter CW, default 16, width of internal counters and oCYCLES.
REQ-007 SHALL have port iCLK  input  1  single clock, all state on rising edge.
REQ-008 SHALL have port iRST  input  1  reset, synchronous, active-high.
REQ-009 SHALL have port iSWRST  input  1  software reset request, sampled each edge.
REQ-010 SHALL have port oRST  output  NDOM  per-domain reset, active-high, bit i = domain i.
REQ-011 SHALL have port oREADY  output  1  high when all domains released.
REQ-012 SHALL have port oDONE  output  1  sticky run-limit reached flag.
REQ-013 SHALL have port oCYCLES  output  CW  run cycles since oREADY rose.

Function
REQ-014 SHALL implement FSM states HOLD, RELEASE, RUN, DONE; all outputs registered.
REQ-015 HOLD: hold counter increments each edge; all oRST=1; on count reaching HOLD, transition to RELEASE with oRST[0] cleared on that edge.
REQ-016 Edge numbering: edge 0 = first edge sampling iRST=0; oRST[i] SHALL clear at edge HOLD+i*STAGGER.
REQ-017 RELEASE: release index advances every STAGGER cycles; released bits SHALL stay cleared.
REQ-018 STAGGER=0: all oRST bits SHALL clear at edge HOLD and FSM SHALL enter RUN directly.
REQ-019 oREADY SHALL rise on the same edge the last oRST bit clears; FSM enters RUN.
REQ-020 RUN: oCYCLES SHALL be 0 on the oREADY edge and increment by 1 per edge thereafter.
REQ-021 RUN_LIMIT>0: on the edge oCYCLES reaches RUN_LIMIT, oDONE SHALL set and FSM enters DONE; oCYCLES SHALL then hold.
REQ-022 RUN_LIMIT=0: oDONE SHALL never set; oCYCLES SHALL saturate at all-ones, never wrap.
REQ-023 DONE with DONE_RST=1: all oRST SHALL reassert and oREADY clear on the oDONE edge, and stay until iRST or iSWRST.
REQ-024 DONE with DONE_RST=0: oRST and oREADY SHALL hold their RUN values.
REQ-025 iSWRST=1 in any state: next edge SHALL set all oRST=1, clear oREADY, oDONE and oCYCLES, and restart HOLD at count 0.
REQ-026 iSWRST held high SHALL keep the FSM in HOLD at count 0; the sequence restarts on the first edge with iSWRST=0.
REQ-027 iRST SHALL take priority over iSWRST on the same edge.
REQ-028 Hold and stagger counters SHALL saturate, never wrap; CW >= clog2(max(HOLD+NDOM*STAGGER, RUN_LIMIT)+1) SHALL be enforced by an elaboration-time check.

Reset
REQ-029 While iRST=1 on an edge: oRST = all ones, oREADY=0, oDONE=0, oCYCLES=0, FSM=HOLD, counters=0.
REQ-030 iRST asserted mid-HOLD, mid-RELEASE, RUN or DONE SHALL produce the REQ-029 state on the next edge, with no partial release retained.

Verification
REQ-031 Defaults, iRST high 3 edges then low -> oRST=2'b10 at edge 10, 2'b00 and oREADY=1 at edge 14, oDONE=1 and oCYCLES=200 at edge 214.
REQ-032 Defaults, iSWRST one-cycle pulse when oCYCLES=50 -> next edge oRST=2'b11, oREADY=0, oCYCLES=0; releases repeat 10/14 edges after the pulse ends.
REQ-033 Defaults, iRST pulse at edge 12 (oRST=2'b10) -> oRST=2'b11 on next edge; full sequence restarts from edge 0 of the new release.
REQ-034 NDOM=4, STAGGER=0 -> all four oRST bits clear together at edge 10, oREADY=1 at edge 10.
REQ-035 RUN_LIMIT=0, CW=8 -> oDONE stays 0; oCYCLES reaches 8'hFF and holds there.
REQ-036 DONE_RST=1, RUN_LIMIT=5 -> at edge 19 oDONE=1, oRST=2'b11, oREADY=0, held until iSWRST pulse restarts the sequence.
